// File: rtl/sirv_regvec_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sirv_regvec_bus_ctrl_pkg
// Brief    : Shared constants, response type and byte-merge helpers for the
//            register-vector bus controller.
// Revision : 1.0 - initial release
// ============================================================================
package sirv_regvec_bus_ctrl_pkg;

    localparam int c_REG_NUM = 8;
    localparam int c_DATA_W  = 32;
    localparam int c_MASK_W  = 4;
    localparam int c_ADDR_W  = 4;
    localparam int c_IDX_W   = $clog2(c_REG_NUM);
    localparam int c_RSP_W   = c_DATA_W + 1;

    typedef struct packed {
        logic                error;
        logic [c_DATA_W-1:0] rdata;
    } rsp_t;

    function automatic logic [c_DATA_W-1:0] expand_mask(input logic [c_MASK_W-1:0] mask);
        logic [c_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < c_MASK_W; i++) begin
            m[8*i +: 8] = {8{mask[i]}};
        end
        return m;
    endfunction

    function automatic logic [c_DATA_W-1:0] merge_bytes(
        input logic [c_DATA_W-1:0] old_val,
        input logic [c_DATA_W-1:0] wdata,
        input logic [c_MASK_W-1:0] mask
    );
        logic [c_DATA_W-1:0] m;
        m = expand_mask(mask);
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sirv_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sirv_rsp_fifo
// Brief    : Power-of-two depth response FIFO with registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sirv_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Head is forced to zero when empty so idle response lines read as zero.
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sirv_regvec_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sirv_regvec_bus_ctrl
// Brief    : Request/response bus front-end for eight external 32-bit register
//            vectors with byte-masked writes and read-after-write forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module sirv_regvec_bus_ctrl
    import sirv_regvec_bus_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic                          a_write,
    input  logic [c_ADDR_W-1:0]           a_addr,
    input  logic [c_DATA_W-1:0]           a_wdata,
    input  logic [c_MASK_W-1:0]           a_mask,
    output logic                          d_valid,
    input  logic                          d_ready,
    output logic [c_DATA_W-1:0]           d_rdata,
    output logic                          d_error,
    output logic [c_REG_NUM-1:0]          reg_en,
    output logic [c_DATA_W-1:0]           reg_d,
    input  logic [c_REG_NUM*c_DATA_W-1:0] reg_q
);
    logic [c_DATA_W-1:0] w_vec [c_REG_NUM];

    logic                r_ws_valid;
    logic [c_IDX_W-1:0]  r_ws_addr;
    logic [c_DATA_W-1:0] r_ws_wdata;
    logic [c_MASK_W-1:0] r_ws_mask;

    logic                w_accept;
    logic                w_legal;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_ws_active;
    logic [c_DATA_W-1:0] w_merged;
    logic [c_DATA_W-1:0] w_rd_val;
    rsp_t                w_push_rsp;
    rsp_t                w_head;
    logic                w_full;
    logic                w_empty;

    generate
        for (genvar n = 0; n < c_REG_NUM; n++) begin : g_vec
            assign w_vec[n] = reg_q[n*c_DATA_W +: c_DATA_W];
        end
    endgenerate

    assign w_accept = a_valid && a_ready && !reset;
    assign w_legal  = (a_addr < c_ADDR_W'(c_REG_NUM));
    assign w_idx    = a_addr[c_IDX_W-1:0];

    // A pending write is dropped in the reset cycle, so no pulse escapes.
    assign w_ws_active = r_ws_valid && !reset;
    assign w_merged    = merge_bytes(w_vec[r_ws_addr], r_ws_wdata, r_ws_mask);

    always_comb begin
        reg_en = '0;
        reg_d  = '0;
        if (w_ws_active) begin
            reg_en[r_ws_addr] = 1'b1;
            reg_d             = w_merged;
        end
    end

    // A read hitting the register being written this cycle sees the new value.
    assign w_rd_val = (w_ws_active && (r_ws_addr == w_idx)) ? w_merged : w_vec[w_idx];

    always_comb begin
        w_push_rsp       = '0;
        w_push_rsp.error = !w_legal;
        if (w_legal && !a_write) begin
            w_push_rsp.rdata = w_rd_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
            r_ws_addr  <= '0;
            r_ws_wdata <= '0;
            r_ws_mask  <= '0;
        end else begin
            r_ws_valid <= w_accept && a_write && w_legal;
            if (w_accept && a_write && w_legal) begin
                r_ws_addr  <= w_idx;
                r_ws_wdata <= a_wdata;
                r_ws_mask  <= a_mask;
            end
        end
    end

    sirv_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (c_RSP_W)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_accept),
        .push_data (w_push_rsp),
        .pop       (d_ready),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign a_ready = !w_full;
    assign d_valid = !w_empty;
    assign d_rdata = w_head.rdata;
    assign d_error = w_head.error;

endmodule
`default_nettype wire

// File: tb/tb_sirv_regvec_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sirv_regvec_bus_ctrl
// Brief    : Scoreboard bench for sirv_regvec_bus_ctrl with an architectural
//            register model and an emulated external register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sirv_regvec_bus_ctrl;

    localparam int c_DEPTH = 2;

    logic         clock   = 1'b0;
    logic         reset   = 1'b1;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic         a_write = 1'b0;
    logic [3:0]   a_addr  = '0;
    logic [31:0]  a_wdata = '0;
    logic [3:0]   a_mask  = '0;
    logic         d_valid;
    logic         d_ready = 1'b0;
    logic [31:0]  d_rdata;
    logic         d_error;
    logic [7:0]   reg_en;
    logic [31:0]  reg_d;
    logic [255:0] reg_q;

    typedef struct {
        logic        error;
        logic [31:0] rdata;
    } exp_rsp_t;

    typedef struct {
        int          cyc;
        logic [7:0]  en;
        logic [31:0] d;
    } exp_wr_t;

    exp_rsp_t    rq[$];
    exp_wr_t     wq[$];
    logic [31:0] ext_regs [8] = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404,
                                  32'h0505_0505, 32'h1122_3344, 32'h0707_0707, 32'h0808_0808};
    logic [31:0] model_regs [8];
    int          cyc       = 0;
    int          n_vec     = 0;
    int          n_err     = 0;
    int          rdy_mode  = 0;

    sirv_regvec_bus_ctrl #(
        .RSP_DEPTH (c_DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_write (a_write),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_mask  (a_mask),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .d_error (d_error),
        .reg_en  (reg_en),
        .reg_d   (reg_d),
        .reg_q   (reg_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // External register vectors controlled by the DUT.
    always @(posedge clock) begin
        for (int n = 0; n < 8; n++) begin
            if (reg_en[n]) ext_regs[n] <= reg_d;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int n = 0; n < 8; n++) reg_q[32*n +: 32] = ext_regs[n];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] old_val,
                                                input logic [31:0] wd,
                                                input logic [3:0]  m);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_accept();
        exp_rsp_t    r;
        exp_wr_t     w;
        logic [31:0] nv;
        int          idx;
        idx     = int'(a_addr);
        r.error = 1'b0;
        r.rdata = '0;
        if (idx >= 8) begin
            r.error = 1'b1;
        end else if (a_write) begin
            nv              = model_merge(model_regs[idx], a_wdata, a_mask);
            model_regs[idx] = nv;
            w.cyc = cyc + 1;
            w.en  = 8'(1 << idx);
            w.d   = nv;
            wq.push_back(w);
        end else begin
            r.rdata = model_regs[idx];
        end
        rq.push_back(r);
    endtask

    task automatic cycle_begin();
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       d_ready = 1'b1;
            1:       d_ready = 1'b0;
            default: d_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (!reset) chk("a_ready", 64'(a_ready), 64'(rq.size() < c_DEPTH));
    endtask

    task automatic issue(input logic wr, input logic [3:0] addr,
                         input logic [31:0] wd, input logic [3:0] m);
        int waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        cycle_begin();
        a_valid = 1'b1;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wd;
        a_mask  = m;
        while (!done) begin
            @(negedge clock);
            if (a_ready) begin
                model_accept();
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    chk("accept_timeout", 64'(a_ready), 64'd1);
                    done = 1'b1;
                end else begin
                    cycle_begin();
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cycle_begin();
            a_valid = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic do_reset(input int n);
        cycle_begin();
        reset   = 1'b1;
        a_valid = 1'b0;
        rq.delete();
        wq.delete();
        repeat (n) cycle_begin();
        reset = 1'b0;
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_d_error", 64'(d_error), 64'd0);
        chk("rst_reg_en",  64'(reg_en),  64'd0);
        chk("rst_reg_d",   64'(reg_d),   64'd0);
        for (int i = 0; i < 8; i++) model_regs[i] = ext_regs[i];
        @(negedge clock);
    endtask

    // Monitor: write-port pulses every cycle, responses on handshake.
    always @(negedge clock) begin
        logic [7:0]  e_en;
        logic [31:0] e_d;
        e_en = '0;
        e_d  = '0;
        if (wq.size() != 0 && wq[0].cyc == cyc) begin
            e_en = wq[0].en;
            e_d  = wq[0].d;
            void'(wq.pop_front());
        end
        chk("reg_en", 64'(reg_en), 64'(e_en));
        if (e_en != 0) chk("reg_d", 64'(reg_d), 64'(e_d));
        if (!reset && d_valid && d_ready) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", 64'(d_valid), 64'd0);
            end else begin
                chk("d_rdata", 64'(d_rdata), 64'(rq[0].rdata));
                chk("d_error", 64'(d_error), 64'(rq[0].error));
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        do_reset(2);
        rdy_mode = 0;

        issue(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
        idle(2);
        issue(1'b1, 4'd5, 32'hAABB_CCDD, 4'h2);
        idle(2);
        issue(1'b1, 4'd2, 32'h1234_5678, 4'hF);
        issue(1'b0, 4'd2, 32'h0, 4'h0);
        idle(2);
        issue(1'b0, 4'd9, 32'h0, 4'h0);
        idle(2);

        rdy_mode = 1;
        issue(1'b0, 4'd0, 32'h0, 4'h0);
        issue(1'b0, 4'd1, 32'h0, 4'h0);
        fork
            issue(1'b0, 4'd5, 32'h0, 4'h0);
            begin
                repeat (4) @(posedge clock);
                rdy_mode = 0;
            end
        join
        idle(4);

        issue(1'b1, 4'd6, 32'hCAFE_F00D, 4'hF);
        do_reset(1);
        issue(1'b0, 4'd6, 32'h0, 4'h0);
        idle(2);

        issue(1'b1, 4'd4, 32'h1111_1111, 4'hF);
        issue(1'b1, 4'd4, 32'h2222_2222, 4'b0101);
        issue(1'b1, 4'd4, 32'h3333_3333, 4'h0);
        issue(1'b0, 4'd4, 32'h0, 4'h0);
        idle(2);

        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                  $urandom,
                  4'($urandom_range(0, 15)));
        end

        rdy_mode = 0;
        t = 0;
        idle(1);
        while ((rq.size() != 0 || wq.size() != 0) && t < 100) begin
            idle(1);
            t++;
        end
        chk("drain_rsp_queue", 64'(rq.size()), 64'd0);
        chk("drain_d_valid", 64'(d_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sirv_regvec_bus_ctrl.md
SIRV_REGVEC_BUS_CTRL -- requirements
Module: sirv_regvec_bus_ctrl

Interface
REQ-001 SHALL have parameter: RSP_DEPTH, default 2, response-FIFO entries (power of 2, >=2).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: a_valid  input  1  request valid.
REQ-005 SHALL have port: a_ready  output  1  request accepted when a_valid&&a_ready.
REQ-006 SHALL have port: a_write  input  1  1=write, 0=read.
REQ-007 SHALL have port: a_addr  input  4  register index; 0-7 legal, 8-15 illegal.
REQ-008 SHALL have port: a_wdata  input  32  write data.
REQ-009 SHALL have port: a_mask  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port: d_valid  output  1  response valid.
REQ-011 SHALL have port: d_ready  input  1  response consumed when d_valid&&d_ready.
REQ-012 SHALL have port: d_rdata  output  32  read data; 0 for writes and errors.
REQ-013 SHALL have port: d_error  output  1  1 = illegal address.
REQ-014 SHALL have port: reg_en  output  8  one-hot write enable to external 32-bit register vectors 0-7.
REQ-015 SHALL have port: reg_d  output  32  shared write data to all register vectors.
REQ-016 SHALL have port: reg_q  input  256  register contents, vector n on bits [32n+31:32n].

Function
REQ-017 SHALL drive a_ready = 1 iff response FIFO holds fewer than RSP_DEPTH entries (registered count; no same-cycle pop bypass).
REQ-018 SHALL push exactly one response per accepted request, in acceptance order.
REQ-019 SHALL, on accepted read of legal addr n, push rdata = reg_q vector n as seen in the accept cycle (after REQ-023 forwarding), error=0.
REQ-020 SHALL, on accepted write of legal addr n, capture n, a_wdata, a_mask into a one-entry write stage; push rdata=0, error=0.
REQ-021 SHALL, in the cycle after a write-stage capture, assert reg_en[n]=1 for exactly one cycle with reg_d = (reg_q[n] & ~M) | (wdata & M), M = byte-expanded mask; reg_en=0 all other cycles.
REQ-022 SHALL, for a_mask=0, still pulse reg_en[n] with reg_d equal to the current value (no-change write).
REQ-023 SHALL, when a read of addr n is accepted in the same cycle reg_en[n] is asserted, return the merged reg_d value (forwarding), not stale reg_q.
REQ-024 SHALL accept back-to-back writes every cycle; each write stage entry drives reg_en in the following cycle, and a write to n followed by a write to n merges the second mask against the first write's reg_d value.
REQ-025 SHALL, on illegal addr (8-15), perform no register write and push rdata=0, error=1.
REQ-026 SHALL present d_valid=1 exactly when FIFO is non-empty; head entry's d_rdata/d_error stable while d_valid&&!d_ready.
REQ-027 SHALL have response latency: push in accept cycle, d_valid earliest in the next cycle.
REQ-028 SHALL, on simultaneous push and pop, keep count unchanged and preserve order; FIFO pointers wrap modulo RSP_DEPTH.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, clear FIFO (count=0, pointers=0), clear write stage, and on the next cycle present a_ready=1, d_valid=0, d_rdata=0, d_error=0, reg_en=0, reg_d=0.
REQ-030 SHALL discard any write pending in the write stage when reset is asserted mid-operation (no reg_en pulse); register vector contents are not affected by this block's reset.
REQ-031 SHALL ignore a_valid in any cycle where reset=1.

Structure
REQ-032 SHALL place register count (8), data width (32), mask width (4) and address width (4) as constants in the shared peripheral package.
REQ-033 SHALL implement the response queue as one sub-module, sirv_rsp_fifo (parameterised depth, 33-bit entry {error,rdata}).

Verification
REQ-034 SHALL cover: write addr 3, wdata 0xDEADBEEF, mask 0xF -> next cycle reg_en=0x08, reg_d=0xDEADBEEF; response rdata=0, error=0.
REQ-035 SHALL cover: reg 5 holds 0x11223344, write mask 0x2 wdata 0xAABBCCDD -> reg_d=0x1122CC44, reg_en=0x20.
REQ-036 SHALL cover: write addr 2 = 0x12345678 then read addr 2 in the next cycle -> read response rdata=0x12345678 (forwarded).
REQ-037 SHALL cover: read addr 9 -> d_error=1, d_rdata=0, reg_en stays 0.
REQ-038 SHALL cover: d_ready=0, three reads issued -> a_ready=0 after 2 accepted; raise d_ready -> responses in order, third accepted once count drops below 2.
REQ-039 SHALL cover: accept write, assert reset the following cycle -> no reg_en pulse, d_valid=0, a_ready=1 after reset.
